// File: rtl/pursuit_host_loader_pkg.sv
// Shared types and default geometry for the matching pursuit host loader.
// The session FSM and the x unloader both use host_state_t.
package verisparse;

   typedef logic [31:0] fp_32_t;

   localparam int SIGNAL_SIZE_DEFAULT       = 4;
   localparam int DICTIONARY_SIZE_DEFAULT   = 8;
   localparam int SIGNAL_ADDR_WIDTH         = 2;
   localparam int DICTIONARY_ADDR_WIDTH     = 5;
   localparam int REPRESENTATION_ADDR_WIDTH = 3;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_LOAD_Y    = 4'd1,
      ST_LOAD_DICT = 4'd2,
      ST_KICK      = 4'd3,
      ST_WAIT      = 4'd4,
      ST_RD_ADDR   = 4'd5,
      ST_RD_DATA   = 4'd6,
      ST_SEND      = 4'd7,
      ST_FINISH    = 4'd8
   } host_state_t;

   // Counter width able to hold depth-1, never narrower than one bit.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pursuit_host_loader_x_unloader.sv
// Reads x[0..N-1] back from the representation RAM and streams each word out
// over valid/ready, one word per three cycles at best.
module pursuit_x_unloader
   import verisparse::*;
#(
   parameter int N    = DICTIONARY_SIZE_DEFAULT,
   parameter int X_AW = REPRESENTATION_ADDR_WIDTH
) (
   input  logic            clock,
   input  logic            resetN,
   input  logic            go,
   output logic [X_AW-1:0] x_raddr,
   input  fp_32_t          x_rdata,
   output logic            out_valid,
   output fp_32_t          out_data,
   input  logic            out_ready,
   output logic            done
);

   localparam int XIW = idx_width(N);

   host_state_t     state_q, state_d;
   logic [XIW-1:0]  idx_q, idx_d;
   logic [XIW-1:0]  idx_inc;
   logic [X_AW-1:0] x_raddr_q, x_raddr_d;
   logic            out_valid_q, out_valid_d;
   fp_32_t          out_data_q, out_data_d;

   assign idx_inc = idx_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      x_raddr_d   = x_raddr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      done        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               state_d   = ST_RD_ADDR;
               idx_d     = '0;
               x_raddr_d = '0;
            end
         end
         ST_RD_ADDR: state_d = ST_RD_DATA;
         ST_RD_DATA: begin
            out_data_d  = x_rdata;
            out_valid_d = 1'b1;
            state_d     = ST_SEND;
         end
         ST_SEND: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (idx_q == XIW'(N - 1)) begin
                  // Combinational so the session FSM reaches FINISH on this same edge.
                  done    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  idx_d     = idx_inc;
                  x_raddr_d = X_AW'(idx_inc);
                  state_d   = ST_RD_ADDR;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         x_raddr_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         x_raddr_q   <= x_raddr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign x_raddr   = x_raddr_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: rtl/pursuit_host_loader.sv
// Host-side session sequencer: loads y and Phi, kicks the processor, waits for
// done, then hands the x readback to pursuit_x_unloader.
module pursuit_host_loader
   import verisparse::*;
#(
   parameter int M    = SIGNAL_SIZE_DEFAULT,
   parameter int N    = DICTIONARY_SIZE_DEFAULT,
   parameter int Y_AW = SIGNAL_ADDR_WIDTH,
   parameter int D_AW = DICTIONARY_ADDR_WIDTH,
   parameter int X_AW = REPRESENTATION_ADDR_WIDTH
) (
   input  logic            clock,
   input  logic            resetN,
   input  logic            cmd_start,
   output logic            busy,
   input  logic            load_valid,
   input  fp_32_t          load_data,
   output logic            load_ready,
   output logic            y_we,
   output logic [Y_AW-1:0] y_waddr,
   output fp_32_t          y_wdata,
   output logic            dict_we,
   output logic [D_AW-1:0] dict_waddr,
   output fp_32_t          dict_wdata,
   output logic [X_AW-1:0] x_raddr,
   input  fp_32_t          x_rdata,
   output logic            proc_start,
   input  logic            proc_done,
   output logic            out_valid,
   output fp_32_t          out_data,
   input  logic            out_ready,
   output logic            session_done
);

   localparam int IW = idx_width(M * N);

   host_state_t     state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            busy_q, busy_d;
   logic            load_ready_q, load_ready_d;
   logic            y_we_q, y_we_d;
   logic [Y_AW-1:0] y_waddr_q, y_waddr_d;
   fp_32_t          y_wdata_q, y_wdata_d;
   logic            dict_we_q, dict_we_d;
   logic [D_AW-1:0] dict_waddr_q, dict_waddr_d;
   fp_32_t          dict_wdata_q, dict_wdata_d;
   logic            proc_start_q, proc_start_d;
   logic            session_done_q, session_done_d;
   logic            accept;
   logic            unl_go;
   logic            unl_done;

   // load_ready_q tracks the load states exactly, so this is the true handshake.
   assign accept = load_valid && load_ready_q;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      y_we_d       = 1'b0;
      y_waddr_d    = y_waddr_q;
      y_wdata_d    = y_wdata_q;
      dict_we_d    = 1'b0;
      dict_waddr_d = dict_waddr_q;
      dict_wdata_d = dict_wdata_q;
      unl_go       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_start) begin
               state_d = ST_LOAD_Y;
               idx_d   = '0;
            end
         end
         ST_LOAD_Y: begin
            if (accept) begin
               y_we_d    = 1'b1;
               y_waddr_d = Y_AW'(idx_q);
               y_wdata_d = load_data;
               if (idx_q == IW'(M - 1)) begin
                  state_d = ST_LOAD_DICT;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_LOAD_DICT: begin
            if (accept) begin
               dict_we_d    = 1'b1;
               dict_waddr_d = D_AW'(idx_q);
               dict_wdata_d = load_data;
               if (idx_q == IW'(M * N - 1)) begin
                  state_d = ST_KICK;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_KICK: state_d = ST_WAIT;
         ST_WAIT: begin
            if (proc_done) begin
               state_d = ST_RD_ADDR;
               idx_d   = '0;
               unl_go  = 1'b1;
            end
         end
         // The unloader walks RD_ADDR/RD_DATA/SEND; here we only wait for it.
         ST_RD_ADDR: begin
            if (unl_done) state_d = ST_FINISH;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_d         = (state_d != ST_IDLE);
      load_ready_d   = (state_d == ST_LOAD_Y) || (state_d == ST_LOAD_DICT);
      proc_start_d   = (state_d == ST_KICK);
      session_done_d = (state_d == ST_FINISH);
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q        <= ST_IDLE;
         idx_q          <= '0;
         busy_q         <= 1'b0;
         load_ready_q   <= 1'b0;
         y_we_q         <= 1'b0;
         y_waddr_q      <= '0;
         y_wdata_q      <= '0;
         dict_we_q      <= 1'b0;
         dict_waddr_q   <= '0;
         dict_wdata_q   <= '0;
         proc_start_q   <= 1'b0;
         session_done_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         busy_q         <= busy_d;
         load_ready_q   <= load_ready_d;
         y_we_q         <= y_we_d;
         y_waddr_q      <= y_waddr_d;
         y_wdata_q      <= y_wdata_d;
         dict_we_q      <= dict_we_d;
         dict_waddr_q   <= dict_waddr_d;
         dict_wdata_q   <= dict_wdata_d;
         proc_start_q   <= proc_start_d;
         session_done_q <= session_done_d;
      end
   end

   pursuit_x_unloader #(
      .N    (N),
      .X_AW (X_AW)
   ) u_unloader (
      .clock     (clock),
      .resetN    (resetN),
      .go        (unl_go),
      .x_raddr   (x_raddr),
      .x_rdata   (x_rdata),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .done      (unl_done)
   );

   assign busy         = busy_q;
   assign load_ready   = load_ready_q;
   assign y_we         = y_we_q;
   assign y_waddr      = y_waddr_q;
   assign y_wdata      = y_wdata_q;
   assign dict_we      = dict_we_q;
   assign dict_waddr   = dict_waddr_q;
   assign dict_wdata   = dict_wdata_q;
   assign proc_start   = proc_start_q;
   assign session_done = session_done_q;

endmodule
